uart_rx_os: RTL

- Parametrised, oversampling UART receiver. Successor to the fixed 8-bit, one-sample-per-bit receiver.
- Adds the following:
  - input synchroniser and glitch rejection
  - 3-sample majority vote per bit
  - configurable data width, parity and stop bits
  - parity and framing error flags
  - valid/ready output with overrun detection
- Sits between the PVT sensor host pad and the command decoder.

---
 rtl/uart_rx_os.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver. A 2-flop synchroniser feeds a
// three-sample majority vote per bit. Supports DATA_BITS, optional odd/even
// parity and 1 or 2 stop bits. Completed frames are offered on a valid/ready
// holding register; a frame that arrives while the register is full is
// dropped and the sticky overrun flag is raised.
module uart_rx_os #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 out_ready,
  input  logic                 overrun_clr,
  output logic                 out_valid,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_parity_err,
  output logic                 out_frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int M   = CLKS_PER_BIT / 2;
  localparam int SCW = $clog2(CLKS_PER_BIT);
  localparam int BIW = $clog2(DATA_BITS);

  // Sample points inside a bit period: M-1, M, M+1; the vote resolves at M+1.
  localparam logic [SCW-1:0] SC_S0   = SCW'(M - 1);
  localparam logic [SCW-1:0] SC_S1   = SCW'(M);
  localparam logic [SCW-1:0] SC_RES  = SCW'(M + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(CLKS_PER_BIT - 1);
  localparam logic [BIW-1:0] BI_LAST = BIW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  // One received frame: payload plus its two error flags.
  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 perr;
    logic                 ferr;
  } frame_t;

  logic           rx_m, rx_s, rx_d;
  logic           fall;
  state_t         state_q, state_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic [BIW-1:0] bidx_q, bidx_d;
  logic           stop_q, stop_d;
  logic [1:0]     samp_q;
  logic           vote;
  logic           at_res, at_wrap, last_stop;
  frame_t         frm_q, frm_d;
  logic           commit_q, commit_d;
  frame_t         hold_q;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign fall    = rx_d & ~rx_s;
  assign at_res  = (sc_q == SC_RES);
  assign at_wrap = (sc_q == SC_LAST);

  // Capture the first two of the three vote samples; the third is rx_s live.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q <= 2'b00;
    end else begin
      if (sc_q == SC_S0) samp_q[0] <= rx_s;
      if (sc_q == SC_S1) samp_q[1] <= rx_s;
    end
  end

  assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s) | (samp_q[1] & rx_s);

  // With one stop bit the first stop is also the last one.
  assign last_stop = (STOP_BITS == 1) || stop_q;

  // Receiver state, counters and frame accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sc_q     <= '0;
      bidx_q   <= '0;
      stop_q   <= 1'b0;
      frm_q    <= '0;
      commit_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sc_q     <= sc_d;
      bidx_q   <= bidx_d;
      stop_q   <= stop_d;
      frm_q    <= frm_d;
      commit_q <= commit_d;
    end
  end

  // Next-state: bit timing, shifting, parity/stop checks and the commit pulse.
  always_comb begin
    state_d  = state_q;
    sc_d     = sc_q;
    bidx_d   = bidx_q;
    stop_d   = stop_q;
    frm_d    = frm_q;
    commit_d = 1'b0;

    if (state_q != S_IDLE) sc_d = at_wrap ? '0 : sc_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        sc_d = '0;
        if (fall) begin
          state_d = S_START;
          bidx_d  = '0;
          stop_d  = 1'b0;
          frm_d   = '0;
        end
      end
      S_START: begin
        // A start bit that votes high was noise: drop back without output.
        if (at_res && vote) begin
          state_d = S_IDLE;
          sc_d    = '0;
        end else if (at_wrap) begin
          state_d = S_DATA;
          bidx_d  = '0;
        end
      end
      S_DATA: begin
        // Shift right so the first (LSB) bit lands at bit 0 after DATA_BITS shifts.
        if (at_res) frm_d.data = {vote, frm_q.data[DATA_BITS-1:1]};
        if (at_wrap) begin
          if (bidx_q == BI_LAST) begin
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
            stop_d  = 1'b0;
          end else begin
            bidx_d = bidx_q + 1'b1;
          end
        end
      end
      S_PAR: begin
        if (at_res) begin
          if (PARITY == 1) frm_d.perr = ~(vote ^ (^frm_q.data));
          else             frm_d.perr =   vote ^ (^frm_q.data);
        end
        if (at_wrap) state_d = S_STOP;
      end
      S_STOP: begin
        if (at_res) begin
          if (!vote) frm_d.ferr = 1'b1;
          // Leave at mid-bit of the last stop so the next start edge is not missed.
          if (last_stop) begin
            state_d  = S_IDLE;
            sc_d     = '0;
            commit_d = 1'b1;
          end
        end
        if (at_wrap && !last_stop) stop_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        sc_d    = '0;
      end
    endcase
  end

  // Output holding register with valid/ready handshake and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      hold_q    <= '0;
      overrun   <= 1'b0;
    end else begin
      if (commit_q && (!out_valid || out_ready)) begin
        hold_q    <= frm_q;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      // A drop in the same cycle as a clear still leaves the flag set.
      if (commit_q && out_valid && !out_ready) overrun <= 1'b1;
      else if (overrun_clr)                    overrun <= 1'b0;
    end
  end

  assign out_data       = hold_q.data;
  assign out_parity_err = hold_q.perr;
  assign out_frame_err  = hold_q.ferr;
  assign busy           = (state_q != S_IDLE);

endmodule
